// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the LSU-to-SRAM-controller bridge.
package sram_bridge_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   localparam int unsigned SRAM_SPAN_BYTES = 1 << 19;
   localparam int          SRAM_SPAN_LOG2  = 19;

   // Size code 2'b11 is reserved; halves need addr[0]=0, words need addr[1:0]=0.
   function automatic logic size_align_err(input logic [1:0] size, input logic [1:0] a);
      return (size == 2'b11) ||
             ((size == SZ_H) && a[0]) ||
             ((size == SZ_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/sram_lsu_bridge_if.sv
// LSU request/response channel plus SRAM-controller strobe bus seen by the bridge.
interface sram_lsu_bridge_if;

   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic [1:0]  i_req_size;
   logic        i_req_unsigned;

   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;

   logic [17:0] o_ADDR;
   logic [31:0] o_WDATA;
   logic [3:0]  o_BMASK;
   logic        o_WREN;
   logic        o_RDEN;
   logic [31:0] i_RDATA;
   logic        i_ACK;

   // Bridge side.
   modport master (
      input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
      output o_req_ready,
      output o_rsp_valid, o_rsp_rdata, o_rsp_err,
      input  i_rsp_ready,
      output o_ADDR, o_WDATA, o_BMASK, o_WREN, o_RDEN,
      input  i_RDATA, i_ACK
   );

   // LSU plus controller side.
   modport slave (
      output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
      input  o_req_ready,
      input  o_rsp_valid, o_rsp_rdata, o_rsp_err,
      output i_rsp_ready,
      input  o_ADDR, o_WDATA, o_BMASK, o_WREN, o_RDEN,
      output i_RDATA, i_ACK
   );

endinterface

// File: rtl/sram_lsu_bridge_lane_align.sv
// Combinational byte-lane steering: store replication/byte mask, load extraction/extension.
module sram_lane_align
   import sram_bridge_pkg::*;
(
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  byte_off_i,
   input  logic        unsigned_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] st_wdata_o,
   output logic [3:0]  st_bmask_o,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] lane_data;
      logic       lane_en;

      // Loads enable every lane and drive no data.
      always_comb begin
         lane_data = 8'h00;
         lane_en   = 1'b0;
         if (!we_i) begin
            lane_en = 1'b1;
         end else begin
            case (size_i)
               SZ_B: begin
                  lane_data = st_data_i[7:0];
                  lane_en   = (byte_off_i == LANE);
               end
               SZ_H: begin
                  lane_data = st_data_i[8*(gi%2) +: 8];
                  lane_en   = (byte_off_i[1] == LANE[1]);
               end
               SZ_W: begin
                  lane_data = st_data_i[8*gi +: 8];
                  lane_en   = 1'b1;
               end
               default: ;
            endcase
         end
      end

      assign st_wdata_o[8*gi +: 8] = lane_data;
      assign st_bmask_o[gi]        = lane_en;
   end

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte = ld_rdata_i[7:0];
      case (byte_off_i)
         2'd1:    ld_byte = ld_rdata_i[15:8];
         2'd2:    ld_byte = ld_rdata_i[23:16];
         2'd3:    ld_byte = ld_rdata_i[31:24];
         default: ld_byte = ld_rdata_i[7:0];
      endcase
      ld_half = byte_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

      ld_data_o = ld_rdata_i;
      case (size_i)
         SZ_B:    ld_data_o = {{24{ld_byte[7] & ~unsigned_i}}, ld_byte};
         SZ_H:    ld_data_o = {{16{ld_half[15] & ~unsigned_i}}, ld_half};
         default: ld_data_o = ld_rdata_i;
      endcase
   end

endmodule

// File: rtl/sram_lsu_bridge.sv
// Single-outstanding LSU initiator for the IS61WV25616 SRAM controller:
// validates a request, issues one enable pulse, waits for ACK or timeout, returns a response.
module sram_lsu_bridge
   import sram_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          TIMEOUT   = 16
)
(
   input  logic               i_clk,
   input  logic               i_reset,
   sram_lsu_bridge_if.master  bus,
   output logic               o_busy
);

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          we_q, we_d;
   logic [1:0]    size_q, size_d;
   logic [1:0]    boff_q, boff_d;
   logic          uns_q, uns_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [16:0]   off_q, off_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   off_full;
   logic [1:0]    unused_off_lsb;
   logic          req_bad;
   logic [31:0]   lane_wdata;
   logic [3:0]    lane_bmask;
   logic [31:0]   ld_data;
   logic          drive_bus;

   // The halfword address only needs off[18:2]; the low offset bits carry no information.
   assign off_full       = bus.i_req_addr - BASE_ADDR;
   assign unused_off_lsb = off_full[1:0];
   assign req_bad        = (|off_full[31:SRAM_SPAN_LOG2]) ||
                           size_align_err(bus.i_req_size, bus.i_req_addr[1:0]);

   sram_lane_align u_align (
      .we_i       (we_q),
      .size_i     (size_q),
      .byte_off_i (boff_q),
      .unsigned_i (uns_q),
      .st_data_i  (wdata_q),
      .st_wdata_o (lane_wdata),
      .st_bmask_o (lane_bmask),
      .ld_rdata_i (bus.i_RDATA),
      .ld_data_o  (ld_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         boff_q  <= 2'b00;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         off_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         boff_q  <= boff_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         off_q   <= off_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      boff_d  = boff_q;
      uns_d   = uns_q;
      wdata_d = wdata_q;
      off_d   = off_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_req_valid) begin
               we_d    = bus.i_req_we;
               size_d  = bus.i_req_size;
               boff_d  = bus.i_req_addr[1:0];
               uns_d   = bus.i_req_unsigned;
               wdata_d = bus.i_req_wdata;
               off_d   = off_full[18:2];
               err_d   = req_bad;
               rdata_d = '0;
               state_d = req_bad ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.i_ACK) begin
               rdata_d = we_q ? 32'h0 : ld_data;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESP: begin
            if (bus.i_rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Controller-facing fields are only meaningful while a request is in flight.
   assign drive_bus       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign bus.o_ADDR      = drive_bus ? {off_q, 1'b0} : 18'h0;
   assign bus.o_WDATA     = drive_bus ? lane_wdata : 32'h0;
   assign bus.o_BMASK     = drive_bus ? lane_bmask : 4'h0;
   assign bus.o_WREN      = (state_q == ST_ISSUE) && we_q;
   assign bus.o_RDEN      = (state_q == ST_ISSUE) && !we_q;

   assign bus.o_req_ready = (state_q == ST_IDLE);
   assign bus.o_rsp_valid = (state_q == ST_RESP);
   assign bus.o_rsp_rdata = rdata_q;
   assign bus.o_rsp_err   = err_q;
   assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_lsu_bridge.sv
// Directed bench for sram_lsu_bridge with a scripted controller ACK per transaction.
module tb_sram_lsu_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   sram_lsu_bridge_if bus();

   sram_lsu_bridge #(.BASE_ADDR(32'h0000_0000), .TIMEOUT(16)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus),
      .o_busy  (busy)
   );

   always #5 clk = ~clk;

   int          vectors    = 0;
   int          miscompares = 0;
   int          lat, wren_cyc, rden_cyc;
   logic [17:0] obs_addr;
   logic [31:0] obs_wdata;
   logic [3:0]  obs_bmask;
   logic [31:0] obs_rdata;
   logic        obs_err;

   // Issue one request; ack_edge = posedges after accept at which ACK is sampled (0 = never).
   task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input int ack_edge,
                          input logic [31:0] rd);
      lat = -1; wren_cyc = 0; rden_cyc = 0;
      obs_addr = '0; obs_wdata = '0; obs_bmask = '0; obs_rdata = 'x; obs_err = 1'bx;
      @(negedge clk);
      bus.i_req_valid = 1'b1; bus.i_req_we = we; bus.i_req_addr = addr;
      bus.i_req_wdata = wd; bus.i_req_size = sz; bus.i_req_unsigned = uns; bus.i_RDATA = rd;
      @(posedge clk);
      #1 bus.i_req_valid = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (bus.o_WREN) wren_cyc++;
         if (bus.o_RDEN) rden_cyc++;
         if (bus.o_WREN || bus.o_RDEN) begin
            obs_addr = bus.o_ADDR; obs_wdata = bus.o_WDATA; obs_bmask = bus.o_BMASK;
         end
         if (bus.o_rsp_valid) begin
            lat = k; obs_rdata = bus.o_rsp_rdata; obs_err = bus.o_rsp_err;
            break;
         end
         bus.i_ACK = (k == ack_edge);
      end
      bus.i_ACK = 1'b0;
      $display("txn we=%0b addr=%08h size=%0d uns=%0b lat=%0d err=%0b rdata=%08h addr18=%05h wdata=%08h bmask=%04b",
               we, addr, sz, uns, lat, obs_err, obs_rdata, obs_addr, obs_wdata, obs_bmask);
   endtask

   task automatic finish_rsp();
      @(negedge clk);
      bus.i_rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.i_rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++; if (bus.o_req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.o_req_ready); end
      vectors++; if ({bus.o_rsp_valid, bus.o_rsp_err, bus.o_WREN, bus.o_RDEN, busy} !== 5'b0) begin
         miscompares++; $display("FAIL reset_ctrl: got %05b want 00000", {bus.o_rsp_valid, bus.o_rsp_err, bus.o_WREN, bus.o_RDEN, busy}); end
      vectors++; if ({bus.o_rsp_rdata, bus.o_ADDR, bus.o_WDATA, bus.o_BMASK} !== 86'h0) begin
         miscompares++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h bmask=%b want 0", bus.o_rsp_rdata, bus.o_ADDR, bus.o_WDATA, bus.o_BMASK); end
   endtask

   task automatic test_store_word();
      run_req(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 2'b10, 1'b0, 3, 32'h0);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL sw_latency: got %0d want 4", lat); end
      vectors++; if (wren_cyc !== 1 || rden_cyc !== 0) begin miscompares++; $display("FAIL sw_pulse: got wren=%0d rden=%0d want 1/0", wren_cyc, rden_cyc); end
      vectors++; if (obs_addr !== 18'h00082) begin miscompares++; $display("FAIL sw_addr: got %h want 00082", obs_addr); end
      vectors++; if (obs_wdata !== 32'hDEAD_BEEF || obs_bmask !== 4'b1111) begin
         miscompares++; $display("FAIL sw_lane: got %h/%b want deadbeef/1111", obs_wdata, obs_bmask); end
      vectors++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0) begin miscompares++; $display("FAIL sw_rsp: got err=%b rdata=%h want 0/0", obs_err, obs_rdata); end
      finish_rsp();
   endtask

   task automatic test_store_narrow();
      run_req(1'b1, 32'h0000_0013, 32'h0000_00A5, 2'b00, 1'b0, 3, 32'h0);
      vectors++; if (obs_wdata !== 32'hA5A5_A5A5 || obs_bmask !== 4'b1000 || obs_addr !== 18'h00008) begin
         miscompares++; $display("FAIL sb_lane: got %h/%b/%h want a5a5a5a5/1000/00008", obs_wdata, obs_bmask, obs_addr); end
      vectors++; if (lat !== 4 || obs_err !== 1'b0) begin miscompares++; $display("FAIL sb_rsp: got lat=%0d err=%b want 4/0", lat, obs_err); end
      finish_rsp();
      run_req(1'b1, 32'h0000_0006, 32'h1234_BEEF, 2'b01, 1'b0, 3, 32'h0);
      vectors++; if (obs_wdata !== 32'hBEEF_BEEF || obs_bmask !== 4'b1100 || obs_addr !== 18'h00002) begin
         miscompares++; $display("FAIL sh_lane: got %h/%b/%h want beefbeef/1100/00002", obs_wdata, obs_bmask, obs_addr); end
      finish_rsp();
   endtask

   task automatic test_loads();
      run_req(1'b0, 32'h0000_0002, 32'hFFFF_FFFF, 2'b00, 1'b0, 4, 32'h1280_3344);
      vectors++; if (lat !== 5) begin miscompares++; $display("FAIL lb_latency: got %0d want 5", lat); end
      vectors++; if (rden_cyc !== 1 || wren_cyc !== 0) begin miscompares++; $display("FAIL lb_pulse: got rden=%0d wren=%0d want 1/0", rden_cyc, wren_cyc); end
      vectors++; if (obs_bmask !== 4'b1111 || obs_wdata !== 32'h0 || obs_addr !== 18'h0) begin
         miscompares++; $display("FAIL lb_bus: got %b/%h/%h want 1111/0/0", obs_bmask, obs_wdata, obs_addr); end
      vectors++; if (obs_rdata !== 32'hFFFF_FF80 || obs_err !== 1'b0) begin miscompares++; $display("FAIL lb_signed: got %h err=%b want ffffff80/0", obs_rdata, obs_err); end
      finish_rsp();
      run_req(1'b0, 32'h0000_0002, 32'h0, 2'b00, 1'b1, 4, 32'h1280_3344);
      vectors++; if (obs_rdata !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu: got %h want 00000080", obs_rdata); end
      finish_rsp();
      run_req(1'b0, 32'h0000_0002, 32'h0, 2'b01, 1'b0, 4, 32'h8001_1234);
      vectors++; if (obs_rdata !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_signed: got %h want ffff8001", obs_rdata); end
      finish_rsp();
      run_req(1'b0, 32'h0000_0002, 32'h0, 2'b01, 1'b1, 4, 32'h8001_1234);
      vectors++; if (obs_rdata !== 32'h0000_8001) begin miscompares++; $display("FAIL lhu: got %h want 00008001", obs_rdata); end
      finish_rsp();
      run_req(1'b0, 32'h0007_FFFC, 32'h0, 2'b10, 1'b0, 4, 32'hCAFE_F00D);
      vectors++; if (obs_rdata !== 32'hCAFE_F00D || obs_addr !== 18'h3FFFE || obs_err !== 1'b0) begin
         miscompares++; $display("FAIL lw_top: got %h/%h err=%b want cafef00d/3fffe/0", obs_rdata, obs_addr, obs_err); end
      finish_rsp();
   endtask

   task automatic test_errors();
      run_req(1'b0, 32'h0000_0001, 32'h0, 2'b01, 1'b0, 4, 32'hFFFF_FFFF);
      vectors++; if (lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || (wren_cyc + rden_cyc) !== 0) begin
         miscompares++; $display("FAIL lh_misalign: got lat=%0d err=%b rdata=%h pulses=%0d want 1/1/0/0", lat, obs_err, obs_rdata, wren_cyc + rden_cyc); end
      finish_rsp();
      run_req(1'b0, 32'h0000_0006, 32'h0, 2'b10, 1'b0, 4, 32'hFFFF_FFFF);
      vectors++; if (lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || (wren_cyc + rden_cyc) !== 0) begin
         miscompares++; $display("FAIL lw_misalign: got lat=%0d err=%b rdata=%h pulses=%0d want 1/1/0/0", lat, obs_err, obs_rdata, wren_cyc + rden_cyc); end
      finish_rsp();
      run_req(1'b1, 32'h0000_0000, 32'h1, 2'b11, 1'b0, 3, 32'h0);
      vectors++; if (lat !== 1 || obs_err !== 1'b1 || wren_cyc !== 0) begin
         miscompares++; $display("FAIL size_illegal: got lat=%0d err=%b wren=%0d want 1/1/0", lat, obs_err, wren_cyc); end
      finish_rsp();
      run_req(1'b0, 32'h0008_0000, 32'h0, 2'b10, 1'b0, 4, 32'hFFFF_FFFF);
      vectors++; if (lat !== 1 || obs_err !== 1'b1 || rden_cyc !== 0) begin
         miscompares++; $display("FAIL out_of_window: got lat=%0d err=%b rden=%0d want 1/1/0", lat, obs_err, rden_cyc); end
      finish_rsp();
   endtask

   task automatic test_timeout();
      run_req(1'b0, 32'h0000_0010, 32'h0, 2'b10, 1'b0, 0, 32'h55AA_55AA);
      vectors++; if (lat !== 18 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || rden_cyc !== 1) begin
         miscompares++; $display("FAIL timeout: got lat=%0d err=%b rdata=%h rden=%0d want 18/1/0/1", lat, obs_err, obs_rdata, rden_cyc); end
      finish_rsp();
      @(negedge clk);
      vectors++; if (bus.o_req_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++; $display("FAIL timeout_recover: got ready=%b busy=%b want 1/0", bus.o_req_ready, busy); end
   endtask

   task automatic test_backpressure();
      run_req(1'b0, 32'h0000_0002, 32'h0, 2'b00, 1'b0, 4, 32'h1280_3344);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++; if ({bus.o_rsp_valid, bus.o_req_ready, bus.o_rsp_err} !== 3'b100 || bus.o_rsp_rdata !== 32'hFFFF_FF80) begin
            miscompares++; $display("FAIL rsp_hold[%0d]: got v/rdy/err=%03b rdata=%h want 100/ffffff80", c,
                                    {bus.o_rsp_valid, bus.o_req_ready, bus.o_rsp_err}, bus.o_rsp_rdata); end
      end
      finish_rsp();
   endtask

   task automatic test_stray_ack();
      @(negedge clk);
      bus.i_ACK = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++; if ({bus.o_rsp_valid, busy, bus.o_req_ready, bus.o_RDEN, bus.o_WREN} !== 5'b00100) begin
            miscompares++; $display("FAIL stray_ack[%0d]: got %05b want 00100", c, {bus.o_rsp_valid, busy, bus.o_req_ready, bus.o_RDEN, bus.o_WREN}); end
      end
      bus.i_ACK = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic seen_rsp;
      @(negedge clk);
      bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_addr = 32'h0000_0020; bus.i_req_size = 2'b10;
      @(posedge clk);
      #1 bus.i_req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++; if ({busy, bus.o_req_ready, bus.o_rsp_valid} !== 3'b010) begin
         miscompares++; $display("FAIL reset_mid: got busy/rdy/v=%03b want 010", {busy, bus.o_req_ready, bus.o_rsp_valid}); end
      seen_rsp = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.o_rsp_valid) seen_rsp = 1'b1;
      end
      vectors++; if (seen_rsp !== 1'b0) begin miscompares++; $display("FAIL reset_mid_no_rsp: got %b want 0", seen_rsp); end
      run_req(1'b1, 32'h0000_0104, 32'h0BAD_F00D, 2'b10, 1'b0, 3, 32'h0);
      vectors++; if (lat !== 4 || obs_err !== 1'b0 || obs_wdata !== 32'h0BAD_F00D) begin
         miscompares++; $display("FAIL reset_mid_after: got lat=%0d err=%b wdata=%h want 4/0/0badf00d", lat, obs_err, obs_wdata); end
      finish_rsp();
   endtask

   initial begin
      bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_addr = '0; bus.i_req_wdata = '0;
      bus.i_req_size = '0; bus.i_req_unsigned = 1'b0; bus.i_rsp_ready = 1'b0;
      bus.i_RDATA = '0; bus.i_ACK = 1'b0;
      test_reset();
      test_store_word();
      test_store_narrow();
      test_loads();
      test_errors();
      test_timeout();
      test_backpressure();
      test_stray_ack();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
